aes_round_ctrl: RTL and testbench
=================================

Name: aes_round_ctrl

Overview:
Iterative AES encryption round sequencer. Owns the 128-bit AES state register and the round counter. Drives a shared combinational round datapath (SubBytes -> ShiftRows -> mixColumns -> AddRoundKey) once per round, and fetches round keys from the key schedule over a request/valid handshake. Sits between the block-level valid/ready stream interface and the round datapath.

Parameters:
NR, 10, number of rounds (10/12/14 for AES-128/192/256); the round counter is 4 bits wide.

Ports:
clk  in  1  single clock; all state updates on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
in_valid  in  1  plaintext block valid.
in_ready  out  1  controller can accept a block.
in_block  in  128  plaintext; bits [127:120] = state byte (row0,col0); bytes are column-major.
rk_req  out  1  round-key request.
rk_idx  out  4  index of the requested round key, 0..NR.
rk_valid  in  1  rk is valid for rk_idx.
rk  in  128  round key, same byte order as in_block.
dp_state  out  128  current state, feeds the round datapath.
dp_last  out  1  final round; the datapath must bypass mixColumns.
dp_result  in  128  combinational round result for dp_state/rk/dp_last.
out_valid  out  1  ciphertext valid.
out_ready  in  1  downstream accepts the ciphertext.
out_block  out  128  ciphertext; equals the state register.

Behaviour:
- Reset values: all outputs 0 except in_ready=1. FSM=IDLE, state_q=0, round_q=0.
- FSM states:
  - IDLE: in_ready=1. On in_valid: state_q<=in_block, go to INIT.
  - INIT: rk_req=1, rk_idx=0. On rk_valid: state_q<=state_q^rk, round_q<=1, go to ROUND.
  - ROUND: rk_req=1, rk_idx=round_q, dp_last=(round_q==NR). On rk_valid: state_q<=dp_result. If round_q==NR go to DONE, else round_q++.
  - DONE: out_valid=1. On out_ready go to IDLE, with round_q<=0.
- in_ready is high only in IDLE, so there is no skid path and an input arriving during DONE is stalled. A block cannot be accepted in the same cycle as out_ready; it is accepted in the following IDLE cycle.
- rk_req, rk_idx and dp_last are stable while rk_valid is low. If rk_valid stays low, the FSM holds and state_q is unchanged.
- rk_valid is ignored outside INIT/ROUND. dp_result is sampled only in ROUND when rk_valid=1.
- dp_state=state_q at all times.
- out_block=state_q. It is held stable while out_valid=1 and out_ready=0.
- Latency with rk_valid tied high: out_valid rises NR+2 cycles after the accept edge (12 for NR=10). Throughput is one block per NR+3 cycles.
- rst_n asserted mid-operation: immediate return to IDLE with reset values. The partial block is dropped and no out_valid is produced.
- dp_last is never 1 outside ROUND.

Optional Feature:
AES_ROUND_CTRL_ABORT_EN
- Defined: an extra input port abort (1 bit) is present. abort=1 in any state other than IDLE forces IDLE on the next edge, clears state_q and round_q, and deasserts out_valid. In DONE, abort has priority over out_ready. abort in IDLE is ignored and does not block acceptance of in_valid.
- Undefined: the abort port does not exist, and the FSM behaves exactly as in Behaviour.

Test Plan:
- FIPS-197 C.1 vector, rk_valid tied high, out_ready=1 -> out_block=69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 12 cycles after accept, high for 1 cycle.
- Same vector with rk_valid low for 3 cycles in each of INIT and round 5 -> same ciphertext. rk_idx/rk_req/dp_last held during the stalls, and out_valid delayed by 6 cycles.
- out_ready held low 5 cycles in DONE, in_valid=1 throughout with a second block -> out_block stable, in_ready=0. The second block is accepted the cycle after the out_ready handshake and produces its correct ciphertext.
- Monitor dp_last -> high only while rk_idx=10 in ROUND. With zero key and zero block, output=66e94bd4ef8a2c3b884cfa59ca342b2e.
- rst_n pulsed low asynchronously during round 4 -> outputs return to reset values without a clock edge, no out_valid, and the next block still encrypts correctly.
- (AES_ROUND_CTRL_ABORT_EN) abort during round 7 -> IDLE next cycle, in_ready=1, state_q=0. abort together with out_ready in DONE -> out_valid drops and no handshake is counted.

Source files
------------

// File: rtl/aes_round_ctrl.sv
`timescale 1ns/1ps
// aes_round_ctrl: iterative AES encryption round sequencer.
// Holds the 128-bit AES state and the round counter. Feeds the shared
// combinational round datapath once per round and fetches each round key
// over a req/valid handshake. Block-level valid/ready on both sides.
// Optional build macro: AES_ROUND_CTRL_ABORT_EN adds an 'abort' input that
// returns the sequencer to IDLE from any busy state.
module aes_round_ctrl #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  output logic         rk_req,
  output logic [3:0]   rk_idx,
  input  logic         rk_valid,
  input  logic [127:0] rk,
  output logic [127:0] dp_state,
  output logic         dp_last,
  input  logic [127:0] dp_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block
`ifdef AES_ROUND_CTRL_ABORT_EN
  ,
  input  logic         abort
`endif
);

  localparam logic [3:0] LastRound = 4'(NR);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INIT  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } fsm_e;

  fsm_e         fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [3:0]   round_q, round_d;
  logic         abortReq;

`ifdef AES_ROUND_CTRL_ABORT_EN
  assign abortReq = abort;
`else
  assign abortReq = 1'b0;
`endif

  // The state register is the only data path visible to both the round
  // datapath and the downstream consumer.
  assign dp_state  = state_q;
  assign out_block = state_q;

  // Next-state and handshake outputs; all outputs are decoded from the
  // current FSM state so they stay stable while a key fetch is stalled.
  always_comb begin
    fsm_d     = fsm_q;
    state_d   = state_q;
    round_d   = round_q;
    in_ready  = 1'b0;
    rk_req    = 1'b0;
    rk_idx    = 4'd0;
    dp_last   = 1'b0;
    out_valid = 1'b0;

    case (fsm_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = in_block;
          fsm_d   = INIT;
        end
      end

      INIT: begin
        rk_req = 1'b1;
        rk_idx = 4'd0;
        if (rk_valid) begin
          state_d = state_q ^ rk;
          round_d = 4'd1;
          fsm_d   = ROUND;
        end
      end

      ROUND: begin
        rk_req  = 1'b1;
        rk_idx  = round_q;
        dp_last = (round_q == LastRound);
        if (rk_valid) begin
          state_d = dp_result;
          if (round_q == LastRound) begin
            fsm_d = DONE;
          end else begin
            round_d = round_q + 4'd1;
          end
        end
      end

      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          fsm_d   = IDLE;
          round_d = 4'd0;
        end
      end

      default: begin
        fsm_d   = IDLE;
        state_d = '0;
        round_d = 4'd0;
      end
    endcase

    if (abortReq && (fsm_q != IDLE)) begin
      fsm_d   = IDLE;
      state_d = '0;
      round_d = 4'd0;
    end
  end

  // State, round counter and FSM registers; reset drops any partial block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      round_q <= 4'd0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      round_q <= round_d;
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
`timescale 1ns/1ps
// tb_aes_round_ctrl: directed bench for the AES round sequencer. The bench
// supplies the key schedule and the combinational round datapath itself and
// compares ciphertexts against published AES-128 vectors.
module tb_aes_round_ctrl;

  localparam int NR = 10;

  localparam logic [127:0] C1_PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_PT    = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT    = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] ZERO_CT = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  typedef struct {
    logic [127:0] cipher;
    int           latency;
    int           doneCycles;
    int           holdErr;
    int           lastErr;
    int           lastHigh;
    int           doneBad;
    int           inReadyErr;
    bit           acceptOk;
    bit           readyAfter;
    bit           timeout;
  } res_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_block;
  logic         rk_req;
  logic [3:0]   rk_idx;
  logic         rk_valid;
  logic [127:0] rk;
  logic [127:0] dp_state;
  logic         dp_last;
  logic [127:0] dp_result;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_block;
`ifdef AES_ROUND_CTRL_ABORT_EN
  logic         abort;
`endif

  logic [127:0] rkTab [0:15];
  int total;
  int bad;

  aes_round_ctrl #(.NR(NR)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_block  (in_block),
    .rk_req    (rk_req),
    .rk_idx    (rk_idx),
    .rk_valid  (rk_valid),
    .rk        (rk),
    .dp_state  (dp_state),
    .dp_last   (dp_last),
    .dp_result (dp_result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block)
`ifdef AES_ROUND_CTRL_ABORT_EN
    ,
    .abort     (abort)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference AES byte substitution.
  function automatic logic [7:0] sb(input logic [7:0] b);
    return SBOX[2047 - 8*int'(b) -: 8];
  endfunction

  // Multiply by x in GF(2^8).
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One AES round: SubBytes, ShiftRows, MixColumns (skipped when last), AddRoundKey.
  function automatic logic [127:0] aesRound(input logic [127:0] s, input logic [127:0] k,
                                            input logic last);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) a[i] = sb(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++) b[rr+4*c] = a[rr + 4*((c+rr)%4)];
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = b[4*c]; a1 = b[4*c+1]; a2 = b[4*c+2]; a3 = b[4*c+3];
      if (last) r[127-32*c -: 32] = {a0, a1, a2, a3};
      else r[127-32*c -: 32] = {xt(a0)^xt(a1)^a1^a2^a3, a0^xt(a1)^xt(a2)^a2^a3,
                                a0^a1^xt(a2)^xt(a3)^a3, xt(a0)^a0^a1^a2^xt(a3)};
    end
    return r ^ k;
  endfunction

  // AES-128 key expansion into the round-key table served on rk.
  task automatic expandKey(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]), sb(t[31:24])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rkTab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    for (int r = 11; r < 16; r++) rkTab[r] = '0;
  endtask

  assign rk = rkTab[rk_idx];
  always_comb dp_result = aesRound(dp_state, rk, dp_last);

  // Pushes one block through, starting in the current (IDLE) cycle. Cycle 0
  // is the accept cycle; latency is the first cycle in which out_valid is seen.
  task automatic runBlock(input logic [127:0] blk, input bit haveNext, input logic [127:0] nextBlk,
                          input int initStall, input int midRound, input int midStall,
                          input int readyDelay, output res_t res);
    int stA, stB;
    bit stalled, hsDriven, seen;
    logic prevReq, prevLast;
    logic [3:0] prevIdx;
    logic [127:0] prevState;
    res.cipher = '0; res.latency = 0; res.doneCycles = 0; res.holdErr = 0;
    res.lastErr = 0; res.lastHigh = 0; res.doneBad = 0; res.inReadyErr = 0;
    res.readyAfter = 0; res.timeout = 1;
    res.acceptOk = in_ready;
    stA = initStall; stB = midStall; stalled = 0; hsDriven = 0; seen = 0;
    prevReq = 0; prevLast = 0; prevIdx = 0; prevState = '0;
    in_valid = 1'b1; in_block = blk; out_ready = 1'b0; rk_valid = 1'b1;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      in_valid = haveNext;
      in_block = haveNext ? nextBlk : blk;
      if (hsDriven) begin
        res.readyAfter = in_ready;
        if (out_valid !== 1'b0) res.doneBad++;
        out_ready = 1'b0;
        res.timeout = 0;
        break;
      end
      if (stalled && (rk_req !== prevReq || rk_idx !== prevIdx || dp_last !== prevLast ||
                      dp_state !== prevState)) res.holdErr++;
      if (dp_last === 1'b1) res.lastHigh++;
      if (dp_last !== (rk_req === 1'b1 && rk_idx === 4'(NR))) res.lastErr++;
      if (in_ready !== 1'b0) res.inReadyErr++;
      if (out_valid === 1'b1) begin
        if (!seen) begin
          seen = 1; res.latency = cyc; res.cipher = out_block;
        end else if (out_block !== res.cipher) begin
          res.doneBad++;
        end
        res.doneCycles++;
        if (res.doneCycles > readyDelay) begin
          out_ready = 1'b1; hsDriven = 1;
        end
      end
      rk_valid = 1'b1;
      if (rk_req && rk_idx == 4'd0 && stA > 0) begin
        rk_valid = 1'b0; stA--;
      end else if (rk_req && rk_idx == 4'(midRound) && stB > 0) begin
        rk_valid = 1'b0; stB--;
      end
      stalled = rk_req && !rk_valid;
      prevReq = rk_req; prevIdx = rk_idx; prevLast = dp_last; prevState = dp_state;
    end
    rk_valid = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({in_ready, out_valid, rk_req, dp_last} !== 4'b1000 || rk_idx !== 4'd0) begin
      bad++;
      $display("[TB] FAIL reset_ctrl got rdy=%b ov=%b req=%b last=%b idx=%0d want 1 0 0 0 0",
               in_ready, out_valid, rk_req, dp_last, rk_idx);
    end
    total++;
    if (dp_state !== '0 || out_block !== '0) begin
      bad++;
      $display("[TB] FAIL reset_data got dp=%h out=%h want 0", dp_state, out_block);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || rk_req !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_idle got rdy=%b req=%b want 1 0", in_ready, rk_req);
    end
  endtask

  task automatic test_fips_c1();
    res_t r;
    expandKey(C1_KEY);
    runBlock(C1_PT, 0, '0, 0, 0, 0, 0, r);
    total++;
    if (r.timeout) begin bad++; $display("[TB] FAIL c1_timeout got timeout want completion"); end
    total++;
    if (r.cipher !== C1_CT) begin
      bad++; $display("[TB] FAIL c1_cipher got=%h want=%h", r.cipher, C1_CT);
    end
    total++;
    if (r.latency != NR + 2) begin
      bad++; $display("[TB] FAIL c1_latency got=%0d want=%0d", r.latency, NR + 2);
    end
    total++;
    if (r.doneCycles != 1 || r.doneBad != 0) begin
      bad++; $display("[TB] FAIL c1_outvalid_len got=%0d bad=%0d want 1 0", r.doneCycles, r.doneBad);
    end
    total++;
    if (!r.acceptOk || r.lastErr != 0) begin
      bad++; $display("[TB] FAIL c1_accept_last got acc=%b lastErr=%0d want 1 0", r.acceptOk, r.lastErr);
    end
  endtask

  task automatic test_rk_stall();
    res_t r;
    expandKey(C1_KEY);
    runBlock(C1_PT, 0, '0, 3, 5, 3, 0, r);
    total++;
    if (r.timeout || r.cipher !== C1_CT) begin
      bad++; $display("[TB] FAIL stall_cipher got=%h to=%b want=%h", r.cipher, r.timeout, C1_CT);
    end
    total++;
    if (r.latency != NR + 2 + 6) begin
      bad++; $display("[TB] FAIL stall_latency got=%0d want=%0d", r.latency, NR + 8);
    end
    total++;
    if (r.holdErr != 0) begin
      bad++; $display("[TB] FAIL stall_hold got=%0d changes want 0", r.holdErr);
    end
    total++;
    if (r.lastErr != 0) begin
      bad++; $display("[TB] FAIL stall_dp_last got=%0d errors want 0", r.lastErr);
    end
  endtask

  task automatic test_back_to_back();
    res_t r1, r2;
    expandKey(C1_KEY);
    runBlock(C1_PT, 1, B_PT, 0, 0, 0, 5, r1);
    total++;
    if (r1.timeout || r1.cipher !== C1_CT) begin
      bad++; $display("[TB] FAIL b2b_first_cipher got=%h to=%b want=%h", r1.cipher, r1.timeout, C1_CT);
    end
    total++;
    if (r1.doneCycles != 6 || r1.doneBad != 0) begin
      bad++; $display("[TB] FAIL b2b_done_hold got len=%0d unstable=%0d want 6 0", r1.doneCycles, r1.doneBad);
    end
    total++;
    if (r1.inReadyErr != 0) begin
      bad++; $display("[TB] FAIL b2b_in_ready_busy got=%0d cycles high want 0", r1.inReadyErr);
    end
    total++;
    if (r1.readyAfter !== 1'b1) begin
      bad++; $display("[TB] FAIL b2b_ready_after got=%b want 1", r1.readyAfter);
    end
    expandKey(B_KEY);
    runBlock(B_PT, 0, '0, 0, 0, 0, 0, r2);
    total++;
    if (r2.timeout || r2.cipher !== B_CT) begin
      bad++; $display("[TB] FAIL b2b_second_cipher got=%h to=%b want=%h", r2.cipher, r2.timeout, B_CT);
    end
    total++;
    if (r2.latency != NR + 2) begin
      bad++; $display("[TB] FAIL b2b_second_latency got=%0d want=%0d", r2.latency, NR + 2);
    end
  endtask

  task automatic test_zero_dp_last();
    res_t r;
    expandKey('0);
    runBlock('0, 0, '0, 0, 0, 0, 0, r);
    total++;
    if (r.timeout || r.cipher !== ZERO_CT) begin
      bad++; $display("[TB] FAIL zero_cipher got=%h to=%b want=%h", r.cipher, r.timeout, ZERO_CT);
    end
    total++;
    if (r.lastErr != 0 || r.lastHigh != 1) begin
      bad++; $display("[TB] FAIL zero_dp_last got err=%0d high=%0d want 0 1", r.lastErr, r.lastHigh);
    end
  endtask

  task automatic test_async_reset();
    res_t r;
    bit hit, sawValid;
    expandKey(C1_KEY);
    in_valid = 1'b1; in_block = C1_PT; rk_valid = 1'b1; out_ready = 1'b1;
    hit = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (rk_req === 1'b1 && rk_idx === 4'd4) begin hit = 1; break; end
    end
    total++;
    if (!hit) begin bad++; $display("[TB] FAIL arst_reach_round4 got no round 4 want round 4"); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready, out_valid, rk_req, dp_last} !== 4'b1000 || rk_idx !== 4'd0) begin
      bad++;
      $display("[TB] FAIL arst_ctrl got rdy=%b ov=%b req=%b last=%b idx=%0d want 1 0 0 0 0",
               in_ready, out_valid, rk_req, dp_last, rk_idx);
    end
    total++;
    if (dp_state !== '0 || out_block !== '0) begin
      bad++; $display("[TB] FAIL arst_data got dp=%h out=%h want 0", dp_state, out_block);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sawValid = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) sawValid = 1;
    end
    total++;
    if (sawValid) begin bad++; $display("[TB] FAIL arst_no_output got out_valid=1 want 0"); end
    runBlock(C1_PT, 0, '0, 0, 0, 0, 0, r);
    total++;
    if (r.timeout || r.cipher !== C1_CT) begin
      bad++; $display("[TB] FAIL arst_next_cipher got=%h to=%b want=%h", r.cipher, r.timeout, C1_CT);
    end
  endtask

`ifdef AES_ROUND_CTRL_ABORT_EN
  task automatic test_abort();
    bit hit, seen;
    expandKey(C1_KEY);
    in_valid = 1'b1; in_block = C1_PT; rk_valid = 1'b1; out_ready = 1'b0; abort = 1'b0;
    hit = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (rk_req === 1'b1 && rk_idx === 4'd7) begin hit = 1; break; end
    end
    total++;
    if (!hit) begin bad++; $display("[TB] FAIL abort_reach_round7 got no round 7 want round 7"); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++;
    if (in_ready !== 1'b1 || rk_req !== 1'b0 || dp_state !== '0) begin
      bad++; $display("[TB] FAIL abort_round7 got rdy=%b req=%b dp=%h want 1 0 0", in_ready, rk_req, dp_state);
    end
    in_valid = 1'b1; in_block = C1_PT;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid === 1'b1) begin seen = 1; break; end
    end
    total++;
    if (!seen || out_block !== C1_CT) begin
      bad++; $display("[TB] FAIL abort_pre_done got=%h seen=%b want=%h", out_block, seen, C1_CT);
    end
    abort = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0; out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_block !== '0) begin
      bad++; $display("[TB] FAIL abort_done got ov=%b rdy=%b out=%h want 0 1 0", out_valid, in_ready, out_block);
    end
    expandKey('0);
    abort = 1'b1; in_valid = 1'b1; in_block = '0;
    @(negedge clk);
    abort = 1'b0; in_valid = 1'b0;
    total++;
    if (rk_req !== 1'b1 || rk_idx !== 4'd0) begin
      bad++; $display("[TB] FAIL abort_idle_accept got req=%b idx=%0d want 1 0", rk_req, rk_idx);
    end
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin seen = 1; break; end
    end
    total++;
    if (!seen || out_block !== ZERO_CT) begin
      bad++; $display("[TB] FAIL abort_idle_cipher got=%h seen=%b want=%h", out_block, seen, ZERO_CT);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask
`endif

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_block = '0; rk_valid = 1'b0; out_ready = 1'b0;
`ifdef AES_ROUND_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    for (int i = 0; i < 16; i++) rkTab[i] = '0;
    test_reset();
    test_fips_c1();
    test_rk_stall();
    test_back_to_back();
    test_zero_dp_last();
    test_async_reset();
`ifdef AES_ROUND_CTRL_ABORT_EN
    test_abort();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so a stuck design cannot hang the run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog got no completion want finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
